// File: rtl/codec_reg_init_seq.sv
// Codec register-initialisation sequencer: walks an addr/data table and issues one
// iic_com write per entry, with retry on timeout, inter-write gap and run status.
module codec_reg_init_seq #(
  parameter int NUM_REGS    = 10,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int PASSES      = 1,
  parameter int GAP_CYCLES  = 16,
  parameter int TIMEOUT_CYC = 65535,
  parameter int MAX_RETRY   = 3,
  parameter int AUTO_START  = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Go,
  input  logic              Tbl_We,
  input  logic [3:0]        Tbl_Idx,
  input  logic [ADDR_W-1:0] Tbl_Addr,
  input  logic [DATA_W-1:0] Tbl_Data,
  output logic [1:0]        Start_Sig,
  output logic [ADDR_W-1:0] Addr_Sig,
  output logic [DATA_W-1:0] WrData,
  input  logic              Done_Sig,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [3:0]        Err_Idx,
  output logic [9:0]        Pass_Cnt
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_REQ, S_GAP, S_NEXT, S_FIN
  } state_t;

  // Power-on codec table: {addr[15:8], data[7:0]}.
  function automatic logic [15:0] dflt_entry(input int i);
    case (i)
      0:       dflt_entry = 16'h0017;
      1:       dflt_entry = 16'h0217;
      2:       dflt_entry = 16'h047f;
      3:       dflt_entry = 16'h067f;
      4:       dflt_entry = 16'h0815;
      5:       dflt_entry = 16'h0a06;
      6:       dflt_entry = 16'h0c00;
      7:       dflt_entry = 16'h0e40;
      8:       dflt_entry = 16'h1000;
      9:       dflt_entry = 16'h1201;
      default: dflt_entry = 16'h0000;
    endcase
  endfunction

  state_t              state_reg, state_next;
  logic [3:0]          idx_reg, idx_next;
  logic [3:0]          retry_reg, retry_next;
  logic [9:0]          pass_reg, pass_next;
  logic [16:0]         timer_reg, timer_next;
  logic [GAP_W-1:0]    gap_reg, gap_next;
  logic                redo_reg, redo_next;
  logic                start_reg, start_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic                err_reg, err_next;
  logic [3:0]          err_idx_reg, err_idx_next;
  logic                auto_reg, auto_next;

  logic [ADDR_W-1:0]   tbl_addr [16];
  logic [DATA_W-1:0]   tbl_data [16];
  logic                tbl_wr;

  // Table edits are only accepted while idle and for indices inside the table.
  assign tbl_wr = Tbl_We && !busy_reg && ({1'b0, Tbl_Idx} < 5'(NUM_REGS));

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_tbl
      localparam logic [15:0] DFLT = dflt_entry(gi);
      logic [ADDR_W-1:0] addr_reg;
      logic [DATA_W-1:0] data_reg;

      always_ff @(posedge CLK) begin
        if (RST) begin
          addr_reg <= ADDR_W'(DFLT[15:8]);
          data_reg <= DATA_W'(DFLT[7:0]);
        end else if (tbl_wr && (Tbl_Idx == 4'(gi))) begin
          addr_reg <= Tbl_Addr;
          data_reg <= Tbl_Data;
        end
      end

      assign tbl_addr[gi] = addr_reg;
      assign tbl_data[gi] = data_reg;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= S_IDLE;
      idx_reg     <= '0;
      retry_reg   <= '0;
      pass_reg    <= '0;
      timer_reg   <= '0;
      gap_reg     <= '0;
      redo_reg    <= 1'b0;
      start_reg   <= 1'b0;
      addr_reg    <= '0;
      data_reg    <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      err_idx_reg <= '0;
      auto_reg    <= (AUTO_START != 0);
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      retry_reg   <= retry_next;
      pass_reg    <= pass_next;
      timer_reg   <= timer_next;
      gap_reg     <= gap_next;
      redo_reg    <= redo_next;
      start_reg   <= start_next;
      addr_reg    <= addr_next;
      data_reg    <= data_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      err_idx_reg <= err_idx_next;
      auto_reg    <= auto_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    retry_next   = retry_reg;
    pass_next    = pass_reg;
    timer_next   = timer_reg;
    gap_next     = gap_reg;
    redo_next    = redo_reg;
    start_next   = start_reg;
    addr_next    = addr_reg;
    data_next    = data_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    err_next     = err_reg;
    err_idx_next = err_idx_reg;
    auto_next    = auto_reg;

    case (state_reg)
      S_IDLE: begin
        busy_next = 1'b0;
        if (Go || auto_reg) begin
          state_next   = S_LOAD;
          idx_next     = '0;
          pass_next    = '0;
          retry_next   = '0;
          err_next     = 1'b0;
          err_idx_next = '0;
          busy_next    = 1'b1;
          auto_next    = 1'b0;
        end
      end
      S_LOAD: begin
        addr_next  = tbl_addr[idx_reg];
        data_next  = tbl_data[idx_reg];
        timer_next = '0;
        state_next = S_REQ;
      end
      S_REQ: begin
        // First REQ cycle only raises the request; Done_Sig counts once it is high.
        if (!start_reg) begin
          start_next = 1'b1;
          timer_next = '0;
        end else begin
          timer_next = timer_reg + 17'd1;
          if (Done_Sig) begin
            start_next = 1'b0;
            retry_next = '0;
            redo_next  = 1'b0;
            gap_next   = '0;
            state_next = S_GAP;
          end else if (timer_reg == 17'(TIMEOUT_CYC - 1)) begin
            start_next = 1'b0;
            if (retry_reg < 4'(MAX_RETRY)) begin
              retry_next = retry_reg + 4'd1;
              redo_next  = 1'b1;
              gap_next   = '0;
              state_next = S_GAP;
            end else begin
              err_next     = 1'b1;
              err_idx_next = idx_reg;
              state_next   = S_FIN;
            end
          end
        end
      end
      S_GAP: begin
        gap_next = gap_reg + 1'b1;
        if (gap_reg == GAP_W'(GAP_CYCLES - 1)) begin
          state_next = redo_reg ? S_LOAD : S_NEXT;
        end
      end
      S_NEXT: begin
        if (idx_reg < 4'(NUM_REGS - 1)) begin
          idx_next   = idx_reg + 4'd1;
          state_next = S_LOAD;
        end else begin
          pass_next = pass_reg + 10'd1;
          idx_next  = '0;
          if ((pass_reg + 10'd1) == 10'(PASSES)) begin
            state_next = S_FIN;
          end else begin
            state_next = S_LOAD;
          end
        end
      end
      S_FIN: begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign Start_Sig = {1'b0, start_reg};
  assign Addr_Sig  = addr_reg;
  assign WrData    = data_reg;
  assign Busy      = busy_reg;
  assign Done      = done_reg;
  assign Err       = err_reg;
  assign Err_Idx   = err_idx_reg;
  assign Pass_Cnt  = pass_reg;

endmodule
